// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipelined MIPS controller: opcodes, ALU codes,
// control-bundle field offsets and FSM state encoding.
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE    = 6'b000000;
  localparam logic [5:0] OP_REGIMM   = 6'b000001;
  localparam logic [5:0] OP_J        = 6'b000010;
  localparam logic [5:0] OP_JAL      = 6'b000011;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] OP_BNE      = 6'b000101;
  localparam logic [5:0] OP_BLEZ     = 6'b000110;
  localparam logic [5:0] OP_BGTZ     = 6'b000111;
  localparam logic [5:0] OP_ADDI     = 6'b001000;
  localparam logic [5:0] OP_SLTI     = 6'b001010;
  localparam logic [5:0] OP_ANDI     = 6'b001100;
  localparam logic [5:0] OP_ORI      = 6'b001101;
  localparam logic [5:0] OP_XORI     = 6'b001110;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_LB       = 6'b100000;
  localparam logic [5:0] OP_LH       = 6'b100001;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_SB       = 6'b101000;
  localparam logic [5:0] OP_SH       = 6'b101001;
  localparam logic [5:0] OP_SW       = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_MUL  = 6'b000010;

  localparam int unsigned ALU_ADD = 1;
  localparam int unsigned ALU_SUB = 2;
  localparam int unsigned ALU_MUL = 3;
  localparam int unsigned ALU_SLL = 8;
  localparam int unsigned ALU_SRL = 9;
  localparam int unsigned ALU_SRA = 10;
  localparam int unsigned ALU_AND = 20;
  localparam int unsigned ALU_OR  = 24;
  localparam int unsigned ALU_XOR = 25;
  localparam int unsigned ALU_NOR = 26;
  localparam int unsigned ALU_SLT = 29;

  // ID/EX bundle layout, LSB first
  localparam int unsigned EX_JUMP_LO   = 0;
  localparam int unsigned EX_BRANCH    = 2;
  localparam int unsigned EX_ZEXT      = 3;
  localparam int unsigned EX_REGDST_LO = 4;
  localparam int unsigned EX_ALUSRC    = 6;
  localparam int unsigned EX_ALUOP_LO  = 7;
  // EX/MEM and MEM/WB bundle layouts
  localparam int unsigned MEM_SIZE_LO  = 0;
  localparam int unsigned MEM_WRITE    = 2;
  localparam int unsigned MEM_READ     = 3;
  localparam int unsigned WB_M2R_LO    = 0;
  localparam int unsigned WB_REGWRITE  = 2;

  localparam logic [1:0] MSZ_WORD = 2'd0;
  localparam logic [1:0] MSZ_HALF = 2'd1;
  localparam logic [1:0] MSZ_BYTE = 2'd2;
  localparam logic [1:0] M2R_MEM  = 2'd0;
  localparam logic [1:0] M2R_ALU  = 2'd1;
  localparam logic [1:0] M2R_PC   = 2'd2;
  localparam logic [1:0] RD_RT    = 2'd0;
  localparam logic [1:0] RD_RD    = 2'd1;
  localparam logic [1:0] RD_RA    = 2'd2;
  localparam logic [1:0] JS_NONE  = 2'd0;
  localparam logic [1:0] JS_J     = 2'd1;
  localparam logic [1:0] JS_JR    = 2'd2;

  localparam int unsigned ALUOP_W_DEF = 5;

  function automatic int unsigned ctrl_width(input int unsigned aluop_w);
    return EX_ALUOP_LO + aluop_w;
  endfunction

  localparam int unsigned CTRL_W = ctrl_width(ALUOP_W_DEF);

  // ALU code for an R-type funct; 0 marks an unsupported funct
  function automatic int unsigned rtype_alu(input logic [5:0] fn);
    case (fn)
      FN_ADD, FN_ADDU: return ALU_ADD;
      FN_SUB, FN_SUBU: return ALU_SUB;
      FN_AND:          return ALU_AND;
      FN_OR:           return ALU_OR;
      FN_XOR:          return ALU_XOR;
      FN_NOR:          return ALU_NOR;
      FN_SLT:          return ALU_SLT;
      FN_SLL:          return ALU_SLL;
      FN_SRL:          return ALU_SRL;
      FN_SRA:          return ALU_SRA;
      default:         return 0;
    endcase
  endfunction

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MUL_BUSY,
    ST_FLUSH
  } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake between the pipeline controller (slave) and the IF/ID, hazard
// unit and stage registers of the datapath (master).
interface pipe_ctrl_if #(
  parameter int unsigned CTRL_W = pipe_ctrl_pkg::CTRL_W
);
  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic              id_valid;
  logic              load_use_hazard;
  logic              branch_taken;
  logic              pc_stall;
  logic              ifid_stall;
  logic              ifid_flush;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CTRL_W-1:0] mem_ctrl;
  logic [CTRL_W-1:0] wb_ctrl;
  logic [1:0]        jump_sel_id;
  logic              busy;

  modport slave (
    input  opcode, funct, id_valid, load_use_hazard, branch_taken,
    output pc_stall, ifid_stall, ifid_flush, ex_ctrl, mem_ctrl, wb_ctrl,
           jump_sel_id, busy
  );

  modport master (
    output opcode, funct, id_valid, load_use_hazard, branch_taken,
    input  pc_stall, ifid_stall, ifid_flush, ex_ctrl, mem_ctrl, wb_ctrl,
           jump_sel_id, busy
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational ID-stage decoder: opcode/funct to the EX, MEM and WB
// control bundles. Invalid slots and unknown encodings decode to all zero.
module ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned ALUOP_W = ALUOP_W_DEF,
  parameter int unsigned CTRL_W  = ctrl_width(ALUOP_W)
) (
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic              id_valid,
  output logic [CTRL_W-1:0] ex_b,
  output logic [CTRL_W-1:0] mem_b,
  output logic [CTRL_W-1:0] wb_b,
  output logic [1:0]        jump_sel,
  output logic              is_mul
);

  logic [ALUOP_W-1:0] alu_op;
  logic               alu_src, zero_ext, branch, mem_read, mem_write, reg_write;
  logic [1:0]         reg_dst, mem_size, m2r, jsel;
  int unsigned        ralu;

  always_comb begin
    alu_op    = '0;
    alu_src   = 1'b0;
    zero_ext  = 1'b0;
    branch    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    reg_dst   = RD_RT;
    mem_size  = MSZ_WORD;
    m2r       = M2R_MEM;
    jsel      = JS_NONE;
    is_mul    = 1'b0;
    ralu      = rtype_alu(funct);
    if (id_valid) begin
      unique case (opcode)
        OP_RTYPE: begin
          if (funct == FN_JR) begin
            jsel = JS_JR;
          end else if (ralu != 0) begin
            alu_op    = ALUOP_W'(ralu);
            reg_dst   = RD_RD;
            reg_write = 1'b1;
            m2r       = M2R_ALU;
          end
        end
        OP_SPECIAL2: begin
          if (funct == FN_MUL) begin
            alu_op    = ALUOP_W'(ALU_MUL);
            reg_dst   = RD_RD;
            reg_write = 1'b1;
            m2r       = M2R_ALU;
            is_mul    = 1'b1;
          end
        end
        OP_ADDI, OP_SLTI: begin
          alu_op    = ALUOP_W'((opcode == OP_ADDI) ? ALU_ADD : ALU_SLT);
          alu_src   = 1'b1;
          reg_write = 1'b1;
          m2r       = M2R_ALU;
        end
        OP_ANDI, OP_ORI, OP_XORI: begin
          alu_op    = ALUOP_W'((opcode == OP_ANDI) ? ALU_AND :
                               (opcode == OP_ORI)  ? ALU_OR  : ALU_XOR);
          alu_src   = 1'b1;
          zero_ext  = 1'b1;
          reg_write = 1'b1;
          m2r       = M2R_ALU;
        end
        OP_LW, OP_LH, OP_LB: begin
          alu_op    = ALUOP_W'(ALU_ADD);
          alu_src   = 1'b1;
          mem_read  = 1'b1;
          mem_size  = (opcode == OP_LW) ? MSZ_WORD : (opcode == OP_LH) ? MSZ_HALF : MSZ_BYTE;
          reg_write = 1'b1;
          m2r       = M2R_MEM;
        end
        OP_SW, OP_SH, OP_SB: begin
          alu_op    = ALUOP_W'(ALU_ADD);
          alu_src   = 1'b1;
          mem_write = 1'b1;
          mem_size  = (opcode == OP_SW) ? MSZ_WORD : (opcode == OP_SH) ? MSZ_HALF : MSZ_BYTE;
        end
        OP_BEQ, OP_BNE, OP_REGIMM, OP_BGTZ, OP_BLEZ: begin
          alu_op = ALUOP_W'(ALU_SUB);
          branch = 1'b1;
        end
        OP_J: jsel = JS_J;
        OP_JAL: begin
          jsel      = JS_J;
          reg_write = 1'b1;
          reg_dst   = RD_RA;
          m2r       = M2R_PC;
        end
        default: ;
      endcase
    end

    ex_b = '0;
    ex_b[EX_JUMP_LO +: 2]       = jsel;
    ex_b[EX_BRANCH]             = branch;
    ex_b[EX_ZEXT]               = zero_ext;
    ex_b[EX_REGDST_LO +: 2]     = reg_dst;
    ex_b[EX_ALUSRC]             = alu_src;
    ex_b[EX_ALUOP_LO +: ALUOP_W] = alu_op;
    mem_b = '0;
    mem_b[MEM_SIZE_LO +: 2]     = mem_size;
    mem_b[MEM_WRITE]            = mem_write;
    mem_b[MEM_READ]             = mem_read;
    wb_b = '0;
    wb_b[WB_M2R_LO +: 2]        = m2r;
    wb_b[WB_REGWRITE]           = reg_write;
    jump_sel = jsel;
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined MIPS main controller: ID decode, ID/EX..MEM/WB control registers,
// load-use/mul stalls and branch/jump flushes. CTRL_PERF_EN adds perf counters.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned ALUOP_W     = ALUOP_W_DEF,
  parameter int unsigned MUL_LAT     = 1,
  parameter int unsigned FLUSH_SLOTS = 1
) (
  input  logic        clk,
  input  logic        Reset,
  pipe_ctrl_if.slave  ctrl
`ifdef CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int unsigned CW      = ctrl_width(ALUOP_W);
  localparam int unsigned CNT_MAX = (MUL_LAT > FLUSH_SLOTS) ? MUL_LAT : FLUSH_SLOTS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  ctrl_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic [CW-1:0]    dec_ex, dec_mem, dec_wb;
  logic [CW-1:0]    idex_ex, idex_mem, idex_wb, exmem_mem, exmem_wb, memwb_wb;
  logic [1:0]       dec_js;
  logic             dec_mul;
  logic             run, take_branch, lu_stall, id_go, flush_now, stall_now;
  logic             idex_hold, idex_bubble;

  ctrl_decode #(.ALUOP_W(ALUOP_W), .CTRL_W(CW)) u_decode (
    .opcode   (ctrl.opcode),
    .funct    (ctrl.funct),
    .id_valid (ctrl.id_valid),
    .ex_b     (dec_ex),
    .mem_b    (dec_mem),
    .wb_b     (dec_wb),
    .jump_sel (dec_js),
    .is_mul   (dec_mul)
  );

  // Priority in RUN: branch flush > load-use stall > ID jump / mul issue
  always_comb begin
    run         = (state == ST_RUN);
    take_branch = run && ctrl.branch_taken;
    lu_stall    = run && !ctrl.branch_taken && ctrl.load_use_hazard;
    id_go       = run && !ctrl.branch_taken && !ctrl.load_use_hazard;
    flush_now   = (state == ST_FLUSH) || take_branch || (id_go && dec_js != JS_NONE);
    stall_now   = lu_stall || (state == ST_MUL_BUSY);
    idex_hold   = (state == ST_MUL_BUSY);
    idex_bubble = (state == ST_FLUSH) || take_branch || lu_stall;
  end

  // Counter holds remaining busy cycles; leaving on the 1->0 step keeps
  // MUL_LAT-1 (resp. FLUSH_SLOTS-1) cycles in the busy state.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state  <= ST_RUN;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (ctrl.branch_taken) begin
            if (FLUSH_SLOTS > 1) begin
              state  <= ST_FLUSH;
              cnt    <= CNT_W'(FLUSH_SLOTS - 1);
              busy_q <= 1'b1;
            end
          end else if (id_go && dec_mul && MUL_LAT > 1) begin
            state  <= ST_MUL_BUSY;
            cnt    <= CNT_W'(MUL_LAT - 1);
            busy_q <= 1'b1;
          end
        end
        ST_MUL_BUSY: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state  <= ST_RUN;
            busy_q <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (ctrl.branch_taken) begin
            cnt <= CNT_W'(FLUSH_SLOTS - 1);
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              state  <= ST_RUN;
              busy_q <= 1'b0;
            end
          end
        end
        default: begin
          state  <= ST_RUN;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      idex_ex   <= '0;
      idex_mem  <= '0;
      idex_wb   <= '0;
      exmem_mem <= '0;
      exmem_wb  <= '0;
      memwb_wb  <= '0;
    end else begin
      if (!idex_hold) begin
        idex_ex  <= idex_bubble ? '0 : dec_ex;
        idex_mem <= idex_bubble ? '0 : dec_mem;
        idex_wb  <= idex_bubble ? '0 : dec_wb;
      end
      exmem_mem <= idex_hold ? '0 : idex_mem;
      exmem_wb  <= idex_hold ? '0 : idex_wb;
      memwb_wb  <= exmem_wb;
    end
  end

`ifdef CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (Reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_now && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush_now && perf_flush_cnt != '1) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

  assign ctrl.pc_stall    = stall_now;
  assign ctrl.ifid_stall  = stall_now;
  assign ctrl.ifid_flush  = flush_now;
  assign ctrl.ex_ctrl     = idex_ex;
  assign ctrl.mem_ctrl    = exmem_mem;
  assign ctrl.wb_ctrl     = memwb_wb;
  assign ctrl.jump_sel_id = dec_js;
  assign ctrl.busy        = busy_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: one instance with MUL_LAT=3/FLUSH_SLOTS=2
// and one with default parameters, driven by the same ID/hazard inputs.
module tb_pipe_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       id_valid, lu, br;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.CTRL_W(12)) bus1 ();
  pipe_ctrl_if #(.CTRL_W(12)) bus0 ();

  assign bus1.opcode = opcode;          assign bus0.opcode = opcode;
  assign bus1.funct = funct;            assign bus0.funct = funct;
  assign bus1.id_valid = id_valid;      assign bus0.id_valid = id_valid;
  assign bus1.load_use_hazard = lu;     assign bus0.load_use_hazard = lu;
  assign bus1.branch_taken = br;        assign bus0.branch_taken = br;

`ifdef CTRL_PERF_EN
  logic [31:0] ps1, pf1, ps0, pf0;
`endif

  pipe_ctrl_unit #(.ALUOP_W(5), .MUL_LAT(3), .FLUSH_SLOTS(2)) dut (
    .clk   (clk),
    .Reset (rst),
    .ctrl  (bus1)
`ifdef CTRL_PERF_EN
    , .perf_stall_cnt(ps1), .perf_flush_cnt(pf1)
`endif
  );

  pipe_ctrl_unit #(.ALUOP_W(5), .MUL_LAT(1), .FLUSH_SLOTS(1)) dut_base (
    .clk   (clk),
    .Reset (rst),
    .ctrl  (bus0)
`ifdef CTRL_PERF_EN
    , .perf_stall_cnt(ps0), .perf_flush_cnt(pf0)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ID/EX layout: {alu_op[4:0], alu_src, reg_dst[1:0], zero_ext, branch, jump_sel[1:0]}
  function automatic logic [31:0] mk_ex(input int aluop, input int src, input int rd,
                                        input int zx, input int brn, input int js);
    return 32'((aluop << 7) | (src << 6) | (rd << 4) | (zx << 3) | (brn << 2) | js);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic id_set(input logic [5:0] op, input logic [5:0] fn, input logic v);
    opcode = op; funct = fn; id_valid = v;
  endtask

  task automatic idle();
    id_set(6'd0, 6'd0, 1'b0);
    lu = 1'b0; br = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    lu = 1'b0; br = 1'b0;
    id_set(6'b001000, 6'd0, 1'b1);
    step(); step();
    idle();
    #1;
    check_eq("rst_ex",    bus1.ex_ctrl, 0);
    check_eq("rst_mem",   bus1.mem_ctrl, 0);
    check_eq("rst_wb",    bus1.wb_ctrl, 0);
    check_eq("rst_busy",  bus1.busy, 0);
    check_eq("rst_stall", bus1.pc_stall, 0);
    check_eq("rst_flush", bus1.ifid_flush, 0);
    rst = 1'b0;

    // addi with id_valid low is a bubble
    id_set(6'b001000, 6'd0, 1'b0);
    step();
    check_eq("novalid_ex", bus1.ex_ctrl, 0);

    // addi latency through the three stages
    id_set(6'b001000, 6'd0, 1'b1);
    #1 check_eq("addi_js", bus1.jump_sel_id, 0);
    step();
    check_eq("addi_ex", bus1.ex_ctrl, mk_ex(1, 1, 0, 0, 0, 0));
    idle();
    step();
    check_eq("addi_mem", bus1.mem_ctrl, 0);
    step();
    check_eq("addi_wb", bus1.wb_ctrl, 32'h5);

    // load-use: lw then add held one cycle behind a bubble
    idle(); step(); step();
    id_set(6'b100011, 6'd0, 1'b1);
    step();
    check_eq("lw_ex", bus1.ex_ctrl, mk_ex(1, 1, 0, 0, 0, 0));
    id_set(6'b000000, 6'b100000, 1'b1);
    lu = 1'b1;
    #1;
    check_eq("lu_pc_stall",   bus1.pc_stall, 1);
    check_eq("lu_ifid_stall", bus1.ifid_stall, 1);
    check_eq("lu_flush",      bus1.ifid_flush, 0);
    step();
    check_eq("lu_bubble_ex", bus1.ex_ctrl, 0);
    check_eq("lw_mem",       bus1.mem_ctrl, 32'h8);
    lu = 1'b0;
    #1 check_eq("lu_released", bus1.pc_stall, 0);
    step();
    check_eq("add_ex", bus1.ex_ctrl, mk_ex(1, 0, 1, 0, 0, 0));
    check_eq("lw_wb",  bus1.wb_ctrl, 32'h4);

    // multi-cycle mul (MUL_LAT=3 on dut, 1 on dut_base)
    idle(); step(); step(); step();
    id_set(6'b011100, 6'b000010, 1'b1);
    #1 check_eq("mul_id_stall", bus1.pc_stall, 0);
    step();
    check_eq("mul_ex",        bus1.ex_ctrl, mk_ex(3, 0, 1, 0, 0, 0));
    check_eq("mul_busy1",     bus1.busy, 1);
    check_eq("base_mul_busy", bus0.busy, 0);
    id_set(6'b001101, 6'd0, 1'b1);
    lu = 1'b1;
    #1;
    check_eq("mul_pc_stall1",   bus1.pc_stall, 1);
    check_eq("mul_ifid_stall1", bus1.ifid_stall, 1);
    step();
    check_eq("mul_busy2",     bus1.busy, 1);
    check_eq("mul_hold_ex2",  bus1.ex_ctrl, mk_ex(3, 0, 1, 0, 0, 0));
    check_eq("mul_mem_bub2",  bus1.mem_ctrl, 0);
    lu = 1'b0;
    #1 check_eq("mul_pc_stall2", bus1.pc_stall, 1);
    step();
    check_eq("mul_busy3",    bus1.busy, 0);
    check_eq("mul_hold_ex3", bus1.ex_ctrl, mk_ex(3, 0, 1, 0, 0, 0));
    check_eq("mul_mem_bub3", bus1.mem_ctrl, 0);
    #1 check_eq("mul_pc_stall3", bus1.pc_stall, 0);
    step();
    check_eq("ori_ex",     bus1.ex_ctrl, mk_ex(24, 1, 0, 1, 0, 0));
    check_eq("mul_wb_pre", bus1.wb_ctrl, 0);
    idle();
    step();
    check_eq("mul_wb", bus1.wb_ctrl, 32'h5);

    // branch with simultaneous load-use: flush wins, two bubbles on dut
    idle(); step(); step();
    id_set(6'b000000, 6'b100000, 1'b1);
    br = 1'b1; lu = 1'b1;
    #1;
    check_eq("br_flush0",      bus1.ifid_flush, 1);
    check_eq("br_stall0",      bus1.pc_stall, 0);
    check_eq("base_br_flush0", bus0.ifid_flush, 1);
    step();
    check_eq("br_ex1",   bus1.ex_ctrl, 0);
    check_eq("br_busy1", bus1.busy, 1);
    check_eq("base_br_busy", bus0.busy, 0);
    br = 1'b0; lu = 1'b0;
    #1;
    check_eq("br_flush1",      bus1.ifid_flush, 1);
    check_eq("br_stall1",      bus1.pc_stall, 0);
    check_eq("base_br_flush1", bus0.ifid_flush, 0);
    step();
    check_eq("br_ex2",      bus1.ex_ctrl, 0);
    check_eq("br_busy2",    bus1.busy, 0);
    check_eq("base_br_ex2", bus0.ex_ctrl, mk_ex(1, 0, 1, 0, 0, 0));
    #1 check_eq("br_flush2", bus1.ifid_flush, 0);
    step();
    check_eq("br_ex3", bus1.ex_ctrl, mk_ex(1, 0, 1, 0, 0, 0));

    // jal: one flush, bundle still flows to WB
    idle(); step();
    id_set(6'b000011, 6'd0, 1'b1);
    #1;
    check_eq("jal_js",    bus1.jump_sel_id, 1);
    check_eq("jal_flush", bus1.ifid_flush, 1);
    check_eq("jal_stall", bus1.pc_stall, 0);
    step();
    check_eq("jal_ex", bus1.ex_ctrl, mk_ex(0, 0, 2, 0, 0, 1));
    idle();
    #1 check_eq("jal_flush_off", bus1.ifid_flush, 0);
    step(); step();
    check_eq("jal_wb", bus1.wb_ctrl, 32'h6);

    // jr, beq, sb, unknown opcode
    id_set(6'b000000, 6'b001000, 1'b1);
    #1;
    check_eq("jr_js",    bus1.jump_sel_id, 2);
    check_eq("jr_flush", bus1.ifid_flush, 1);
    step();
    check_eq("jr_ex", bus1.ex_ctrl, mk_ex(0, 0, 0, 0, 0, 2));
    id_set(6'b000100, 6'd0, 1'b1);
    step();
    check_eq("beq_ex", bus1.ex_ctrl, mk_ex(2, 0, 0, 0, 1, 0));
    id_set(6'b101000, 6'd0, 1'b1);
    step();
    check_eq("sb_ex", bus1.ex_ctrl, mk_ex(1, 1, 0, 0, 0, 0));
    id_set(6'b111111, 6'd0, 1'b1);
    step();
    check_eq("sb_mem",     bus1.mem_ctrl, 32'h6);
    check_eq("unknown_ex", bus1.ex_ctrl, 0);

    // branch with jal in ID on the default instance: single flush, jal dropped
    idle(); step();
    id_set(6'b000011, 6'd0, 1'b1);
    br = 1'b1;
    #1 check_eq("base_brj_flush", bus0.ifid_flush, 1);
    step();
    check_eq("base_brj_ex", bus0.ex_ctrl, 0);
    idle();
    #1 check_eq("base_brj_flush_off", bus0.ifid_flush, 0);

    // reset in the middle of MUL_BUSY
    idle(); step(); step();
    id_set(6'b011100, 6'b000010, 1'b1);
    step();
    check_eq("mulrst_busy_pre", bus1.busy, 1);
    rst = 1'b1;
    idle();
    step();
    check_eq("mulrst_busy",  bus1.busy, 0);
    check_eq("mulrst_ex",    bus1.ex_ctrl, 0);
    check_eq("mulrst_mem",   bus1.mem_ctrl, 0);
    check_eq("mulrst_wb",    bus1.wb_ctrl, 0);
    check_eq("mulrst_stall", bus1.pc_stall, 0);
`ifdef CTRL_PERF_EN
    check_eq("mulrst_perf_stall", ps1, 0);
    check_eq("mulrst_perf_flush", pf1, 0);
`endif
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
